// File: rtl/slice_adder_sequencer_if.sv
// Operand/result handshake bundle for the sequenced slice adder.
// The master side is the operand source and the result consumer; the slave side is the adder.
interface slice_adder_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/slice_adder_sequencer.sv
// 4-bit carry-bypass adder slice: combinational, zero latency, no flow control.
// Carry-out skips the ripple chain when every bit propagates.
module carry_bypass_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s    = p ^ c[3:0];
    cout = (&p) ? cin : c[4];
  end
endmodule

// WIDTH-bit adder reusing one 4-bit slice, LSB nibble first; result valid NSLICE cycles after accept.
// in_ready is low from accept until the result is taken; the result is held while out_ready is low.
module slice_adder_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  slice_adder_sequencer_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("slice_adder_sequencer: WIDTH must be a positive multiple of 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_out_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic [CW+1:0]    base;
  logic [3:0]       slice_s;
  logic             slice_co;

  assign base = {cnt, 2'b00};

  carry_bypass_4_bit u_slice (
    .a    (a_reg[base +: 4]),
    .b    (b_reg[base +: 4]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      cnt           <= '0;
      carry         <= 1'b0;
      c_out_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.a;
            b_reg        <= bus.b;
            carry        <= bus.c_in;
            cnt          <= '0;
            state        <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          sum_reg[base +: 4] <= slice_s;
          carry              <= slice_co;
          if (cnt == CW'(NSLICE - 1)) begin
            state         <= DONE;
            c_out_reg     <= slice_co;
            out_valid_reg <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: doc/slice_adder_sequencer.md
Name: slice_adder_sequencer

Overview:
- Multi-cycle wide adder built from one shared 4-bit adder slice (one instance of carry_bypass_4_bit).
- Accepts a WIDTH-bit operand pair over a valid/ready handshake.
- Feeds the slice 4 bits per cycle, LSB nibble first, and chains the slice carry-out through a carry register.
- Presents the WIDTH-bit sum and the final carry on a second valid/ready handshake.
- Sits between the operand source and the result consumer; trades latency for area.

Parameters:
- WIDTH, 32: operand/sum width. Must be a multiple of 4 and at least 4; elaboration fails otherwise.
- NSLICE, WIDTH/4: derived, not overridable. Number of slice passes per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in into bit 0
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  A + B + c_in, low WIDTH bits
- c_out  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, slice counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a, b, c_in into operand registers, load carry register with c_in, clear counter to 0, go to RUN.
- RUN:
  - in_ready=0.
  - Slice inputs: a_reg[4k+3:4k], b_reg[4k+3:4k], carry register, where k=counter.
  - Each clock: write the slice sum to sum[4k+3:4k], write the slice carry-out to the carry register, increment k.
  - When k==NSLICE-1, go to DONE instead of incrementing.
  - Entering DONE, c_out takes the final slice carry-out.
- DONE:
  - out_valid=1; sum and c_out held stable.
  - On out_ready, go to IDLE; out_valid drops on the next edge.
  - out_ready held high gives a one-cycle DONE.
- Latency:
  - Accept edge at cycle T; out_valid is first high in cycle T+NSLICE.
  - 8 cycles for WIDTH=32; 1 cycle for WIDTH=4.
  - Minimum issue interval is NSLICE+2 cycles (accept, NSLICE-1 further RUN cycles, DONE, IDLE).
- Handshake rules:
  - in_ready depends only on state (no combinational path from out_ready).
  - Operands changing while not accepted are ignored.
  - sum bits not yet written during RUN are don't-care; the consumer samples only under out_valid.
- Boundaries:
  - all-ones + all-ones + 1 gives sum all-ones, c_out=1.
  - Carry must ripple through every slice boundary across cycles.
  - in_valid in RUN/DONE is not accepted; the source must hold it.
  - out_ready while not DONE is ignored.
  - rst in any state returns to the reset values on the next edge and discards the operation in flight; the in_ready rule still holds in the reset cycle.
- Arithmetic: unsigned; {c_out,sum} = a + b + c_in exactly, WIDTH+1 bits.

Test Plan:
- Reset then a=0x0000_0001, b=0x0000_0001, c_in=0, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=0x0000_0002, c_out=0; in_ready back to 1 one cycle later.
- a=0xFFFF_FFFF, b=0x0000_0000, c_in=1 -> sum=0x0000_0000, c_out=1 (carry crosses all 7 slice boundaries).
- a=0x89AB_CDEF, b=0x7654_3210, c_in=0, out_ready held low 5 cycles in DONE -> sum=0xFFFF_FFFF, c_out=0, stable all 5 cycles; in_valid with new operands in that window is not accepted.
- rst asserted in RUN at k=3 during 0xFFFF_FFFF+1 -> next cycle IDLE, out_valid=0, sum=0, c_out=0; a following 5+6 returns 11 with c_out=0.
- Back-to-back: 1000 random operand pairs with random in_valid/out_ready gaps -> every result matches the 33-bit reference sum; no accept while busy=1; no lost or duplicated results.
- WIDTH=4 build: a=0xF, b=0x1, c_in=0 -> out_valid one cycle after accept, sum=0x0, c_out=1.
